// File: rtl/lockout_timer.sv
`default_nettype none
// ============================================================================
// Module   : lockout_timer
// Purpose  : Loadable, prescaled down-counter. A start pulse loads a step
//            count; every PRESCALE clocks the count drops by one until it
//            reaches zero, which produces a single-cycle expired pulse.
//            Supports pause, abort and retrigger while counting.
// Options  : LOCKOUT_TIMER_AUTO_RELOAD_EN - when defined, expiry reloads the
//            last non-zero load value and keeps running (periodic timer).
// Revision : 1.0 - initial release
// ============================================================================
module lockout_timer #(
    parameter int BITS     = 8,
    parameter int PRESCALE = 50000000,
    parameter int PS_BITS  = 26
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [BITS-1:0] load_val,
    input  logic            pause,
    input  logic            abort,
    output logic            busy,
    output logic            expired,
    output logic            step_tick,
    output logic [BITS-1:0] remaining
);

    // Last prescaler value before a step is taken.
    localparam logic [PS_BITS-1:0] PS_LAST = PS_BITS'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [PS_BITS-1:0] prescaler;
    logic [PS_BITS-1:0] prescaler_n;
    logic [BITS-1:0]    remaining_n;
    logic               busy_n;
    logic               expired_n;
    logic               step_tick_n;

`ifdef LOCKOUT_TIMER_AUTO_RELOAD_EN
    logic [BITS-1:0]    reload;
    logic [BITS-1:0]    reload_n;

    // Reload latch holds the most recent non-zero load value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reload <= '0;
        end else begin
            reload <= reload_n;
        end
    end
`endif

    // State, prescaler and all outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            prescaler <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            expired   <= 1'b0;
            step_tick <= 1'b0;
        end else begin
            state     <= state_n;
            prescaler <= prescaler_n;
            remaining <= remaining_n;
            busy      <= busy_n;
            expired   <= expired_n;
            step_tick <= step_tick_n;
        end
    end

    // Next-state logic: abort beats start, start beats pause, pause beats counting.
    always_comb begin
        state_n     = state;
        prescaler_n = prescaler;
        remaining_n = remaining;
        busy_n      = busy;
        expired_n   = 1'b0;
        step_tick_n = 1'b0;
`ifdef LOCKOUT_TIMER_AUTO_RELOAD_EN
        reload_n    = reload;
`endif
        if (abort) begin
            state_n     = IDLE;
            prescaler_n = '0;
            remaining_n = '0;
            busy_n      = 1'b0;
        end else if (start) begin
            // Load (or retrigger); any tick or expiry due on this edge is dropped.
            prescaler_n = '0;
            remaining_n = load_val;
            if (load_val != '0) begin
                state_n  = RUN;
                busy_n   = 1'b1;
`ifdef LOCKOUT_TIMER_AUTO_RELOAD_EN
                reload_n = load_val;
`endif
            end else begin
                state_n   = IDLE;
                busy_n    = 1'b0;
                expired_n = 1'b1;
            end
        end else if (state != IDLE) begin
            if (pause) begin
                // Freeze prescaler and count.
                state_n = PAUSED;
            end else begin
                // Counting happens on every edge that sees pause low, including
                // the edge that leaves PAUSED, so paused time adds exactly.
                state_n = RUN;
                if (prescaler == PS_LAST) begin
                    prescaler_n = '0;
                    step_tick_n = 1'b1;
                    if (remaining > BITS'(1)) begin
                        remaining_n = remaining - BITS'(1);
                    end else begin
                        expired_n = 1'b1;
`ifdef LOCKOUT_TIMER_AUTO_RELOAD_EN
                        remaining_n = reload;
`else
                        remaining_n = '0;
                        state_n     = IDLE;
                        busy_n      = 1'b0;
`endif
                    end
                end else begin
                    prescaler_n = prescaler + PS_BITS'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lockout_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lockout_timer
// Purpose  : Scoreboard bench for lockout_timer with PRESCALE=4. Stimulus
//            pushes expected tick/expiry events (cycle, flags, remaining,
//            busy); a monitor pops and compares whenever the DUT pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lockout_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] load_val;
    logic       pause;
    logic       abort;
    logic       busy;
    logic       expired;
    logic       step_tick;
    logic [7:0] remaining;

    lockout_timer #(.BITS(8), .PRESCALE(4), .PS_BITS(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .load_val  (load_val),
        .pause     (pause),
        .abort     (abort),
        .busy      (busy),
        .expired   (expired),
        .step_tick (step_tick),
        .remaining (remaining)
    );

    always #5 clk = ~clk;

    // Count of rising edges seen; events are identified by this number.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         ecyc;
        logic       tick;
        logic       exp;
        logic [7:0] rem;
        logic       bsy;
    } ev_t;

    ev_t q[$];
    ev_t mon_e;
    int  total = 0;
    int  passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: actual=%0d required=%0d (cyc %0d)", name, act, req, cyc);
    endtask

    task automatic push_ev(input int c, input logic t, input logic e, input logic [7:0] r, input logic b);
        ev_t v;
        v.ecyc = c; v.tick = t; v.exp = e; v.rem = r; v.bsy = b;
        q.push_back(v);
    endtask

    // Called at a negedge; returns the start edge number and leaves at its negedge.
    task automatic do_start(input logic [7:0] v, output int s);
        start    = 1'b1;
        load_val = v;
        s        = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every tick/expiry pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (!rst && (step_tick || expired)) begin
            if (q.size() == 0) begin
                total++;
                $display("FAIL unexpected_event: actual tick=%0b expired=%0b rem=%0d required no event (cyc %0d)",
                         step_tick, expired, remaining, cyc);
            end else begin
                mon_e = q.pop_front();
                check("ev_cycle", cyc, mon_e.ecyc);
                check("ev_tick", step_tick, mon_e.tick);
                check("ev_expired", expired, mon_e.exp);
                check("ev_remaining", remaining, mon_e.rem);
                check("ev_busy", busy, mon_e.bsy);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int s2;
        int n;
        rst = 1'b1; start = 1'b0; load_val = '0; pause = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_remaining", remaining, 0);
        check("reset_busy", busy, 0);
        check("reset_expired", expired, 0);
        check("reset_tick", step_tick, 0);
        rst = 1'b0;
        @(negedge clk);

        // Asynchronous reset mid-run with remaining=5.
        do_start(8'd5, s);
        wait_until(s + 2);
        check("pre_rst_remaining", remaining, 5);
        check("pre_rst_busy", busy, 1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_remaining", remaining, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_expired", expired, 0);
        check("async_rst_tick", step_tick, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

`ifndef LOCKOUT_TIMER_AUTO_RELOAD_EN
        // Plain countdown of 3 steps.
        do_start(8'd3, s);
        check("run_busy", busy, 1);
        check("run_remaining", remaining, 3);
        push_ev(s + 4, 1, 0, 8'd2, 1);
        push_ev(s + 8, 1, 0, 8'd1, 1);
        push_ev(s + 12, 1, 1, 8'd0, 0);
        wait_until(s + 14);

        // Pause for 10 clocks after the first tick.
        do_start(8'd3, s);
        push_ev(s + 4, 1, 0, 8'd2, 1);
        push_ev(s + 18, 1, 0, 8'd1, 1);
        push_ev(s + 22, 1, 1, 8'd0, 0);
        wait_until(s + 4);
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("paused_remaining", remaining, 2);
            check("paused_busy", busy, 1);
        end
        pause = 1'b0;
        wait_until(s + 24);

        // Abort with remaining=2.
        do_start(8'd3, s);
        push_ev(s + 4, 1, 0, 8'd2, 1);
        wait_until(s + 5);
        check("pre_abort_remaining", remaining, 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_remaining", remaining, 0);
        check("abort_busy", busy, 0);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (expired) n++;
        end
        check("abort_no_expiry", n, 0);

        // Start with zero from IDLE: immediate expiry, never busy.
        start    = 1'b1;
        load_val = 8'd0;
        push_ev(cyc + 1, 0, 1, 8'd0, 0);
        @(negedge clk);
        start = 1'b0;
        check("zero_load_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("zero_load_busy_later", busy, 0);

        // Retrigger with 5 on the edge that would have expired.
        do_start(8'd2, s);
        push_ev(s + 4, 1, 0, 8'd1, 1);
        wait_until(s + 7);
        start    = 1'b1;
        load_val = 8'd5;
        @(negedge clk);
        start = 1'b0;
        s2 = s + 8;
        check("retrig_remaining", remaining, 5);
        check("retrig_busy", busy, 1);
        push_ev(s2 + 4, 1, 0, 8'd4, 1);
        push_ev(s2 + 8, 1, 0, 8'd3, 1);
        push_ev(s2 + 12, 1, 0, 8'd2, 1);
        push_ev(s2 + 16, 1, 0, 8'd1, 1);
        push_ev(s2 + 20, 1, 1, 8'd0, 0);
        wait_until(s2 + 22);
`else
        // Periodic mode: load 2, expiry every 8 clocks, then abort.
        do_start(8'd2, s);
        push_ev(s + 4, 1, 0, 8'd1, 1);
        push_ev(s + 8, 1, 1, 8'd2, 1);
        push_ev(s + 12, 1, 0, 8'd1, 1);
        push_ev(s + 16, 1, 1, 8'd2, 1);
        wait_until(s + 17);
        check("reload_busy", busy, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("reload_abort_busy", busy, 0);
        check("reload_abort_remaining", remaining, 0);
        repeat (12) @(negedge clk);
`endif

        check("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
